// File: rtl/simon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : simon_pkg
// Description : Shared types and constants for the Simon sequence engine:
//               the game state encoding and the LFSR reset/zero-seed value.
// Revision    : 1.0 - initial release
// ============================================================================
package simon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXTEND  = 3'd1,
    ST_SHOW    = 3'd2,
    ST_WAIT_IN = 3'd3,
    ST_FAIL    = 3'd4,
    ST_WIN     = 3'd5
  } state_t;

  // An all-zero Fibonacci LFSR locks up, so zero is never allowed as a seed.
  localparam logic [15:0] LFSR_RESET_SEED = 16'hACE1;

  function automatic logic [15:0] fix_seed(input logic [15:0] s);
    return (s == 16'h0000) ? LFSR_RESET_SEED : s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/simon_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : simon_lfsr
// Description : 16-bit Fibonacci LFSR, taps 16,14,13,11 (x^16+x^14+x^13+x^11+1),
//               shifting toward the MSB. Load has priority over step.
// Revision    : 1.0 - initial release
// ============================================================================
module simon_lfsr (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] value
);
  import simon_pkg::*;

  logic feedback;

  assign feedback = value[15] ^ value[13] ^ value[12] ^ value[10];

  // Shift register: reload on a new game, advance once per appended symbol.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= LFSR_RESET_SEED;
    end else if (load) begin
      value <= fix_seed(seed);
    end else if (step) begin
      value <= {value[14:0], feedback};
    end
  end

endmodule
`default_nettype wire

// File: rtl/simon_sequence_engine.sv
`default_nettype none
// ============================================================================
// Module      : simon_sequence_engine
// Description : Simon memory-game engine. Grows a pseudo-random symbol
//               sequence one entry per round, plays it back over a
//               valid/ready port, then checks the player's button presses.
//               Optional build macro SIMON_TIMEOUT_EN adds an inactivity
//               timeout while waiting for presses.
// Revision    : 1.0 - initial release
// ============================================================================
module simon_sequence_engine #(
  parameter int NUM_BTN     = 4,
  parameter int MAX_LEN     = 16,
  parameter int TIMEOUT_CYC = 1000000,
  localparam int SYM_W      = $clog2(NUM_BTN),
  localparam int LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [15:0]        seed,
  input  logic [NUM_BTN-1:0] buttons,
  output logic               show_valid,
  output logic [SYM_W-1:0]   show_sym,
  input  logic               show_ready,
  output logic [LEN_W-1:0]   round_len,
  output logic [LEN_W-1:0]   input_index,
  output logic               round_pass,
  output logic               input_error,
  output logic               game_won,
  output logic               busy
);
  import simon_pkg::*;

  localparam int ADDR_W = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] ONE_LEN = LEN_W'(1);
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(MAX_LEN);

  state_t state, state_next;

  logic [SYM_W-1:0] seq_mem [MAX_LEN];
  logic [LEN_W-1:0] show_idx;
  logic             prev_zero;
  logic [15:0]      lfsr;

  logic [SYM_W-1:0]   new_sym;
  logic [SYM_W-1:0]   expect_sym;
  logic [NUM_BTN-1:0] expect_onehot;
  logic [LEN_W-1:0]   last_idx;
  logic               press;
  logic               tmo_hit;

  logic start_game, append, show_adv, enter_wait;
  logic press_ok, press_bad, pass_now, timeout_now;

  simon_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (start_game),
    .seed  (seed),
    .step  (append),
    .value (lfsr)
  );

  assign new_sym       = SYM_W'(32'(lfsr[SYM_W-1:0]) % NUM_BTN);
  assign expect_sym    = seq_mem[input_index[ADDR_W-1:0]];
  assign expect_onehot = NUM_BTN'(1) << expect_sym;
  assign last_idx      = round_len - ONE_LEN;

  // A press is a zero-to-nonzero transition seen while waiting; buttons
  // held from before WAIT_IN never satisfy prev_zero.
  assign press = (state == ST_WAIT_IN) && prev_zero && (buttons != '0);

  assign show_valid  = (state == ST_SHOW);
  assign show_sym    = show_valid ? seq_mem[show_idx[ADDR_W-1:0]] : '0;
  assign game_won    = (state == ST_WIN);
  assign busy        = (state == ST_EXTEND) || (state == ST_SHOW) || (state == ST_WAIT_IN);

  logic unused_lfsr;
  assign unused_lfsr = ^lfsr[15:SYM_W];

`ifdef SIMON_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] idle_cnt;

  assign tmo_hit = (idle_cnt == TMO_W'(TIMEOUT_CYC - 1));

  // Idle counter: restarts on WAIT_IN entry and on every press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if ((state != ST_WAIT_IN) || press) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + TMO_W'(1);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign tmo_hit        = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and per-cycle datapath controls.
  always_comb begin
    state_next  = state;
    start_game  = 1'b0;
    append      = 1'b0;
    show_adv    = 1'b0;
    enter_wait  = 1'b0;
    press_ok    = 1'b0;
    press_bad   = 1'b0;
    pass_now    = 1'b0;
    timeout_now = 1'b0;
    case (state)
      ST_IDLE, ST_FAIL, ST_WIN: begin
        if (start) begin
          start_game = 1'b1;
          state_next = ST_EXTEND;
        end
      end
      ST_EXTEND: begin
        append     = 1'b1;
        state_next = ST_SHOW;
      end
      ST_SHOW: begin
        if (show_ready) begin
          if (show_idx == last_idx) begin
            enter_wait = 1'b1;
            state_next = ST_WAIT_IN;
          end else begin
            show_adv = 1'b1;
          end
        end
      end
      ST_WAIT_IN: begin
        if (press) begin
          if (buttons == expect_onehot) begin
            press_ok = 1'b1;
            if (input_index == last_idx) begin
              pass_now   = 1'b1;
              state_next = (round_len == FULL_LEN) ? ST_WIN : ST_EXTEND;
            end
          end else begin
            press_bad  = 1'b1;
            state_next = ST_FAIL;
          end
        end else if (tmo_hit) begin
          timeout_now = 1'b1;
          state_next  = ST_FAIL;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Sequence storage, round/playback/input counters and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_LEN; i++) seq_mem[i] <= '0;
      round_len   <= '0;
      input_index <= '0;
      show_idx    <= '0;
      prev_zero   <= 1'b0;
      round_pass  <= 1'b0;
      input_error <= 1'b0;
    end else begin
      prev_zero  <= (buttons == '0);
      round_pass <= pass_now;
      if (start_game) begin
        for (int i = 0; i < MAX_LEN; i++) seq_mem[i] <= '0;
        round_len   <= '0;
        input_index <= '0;
        show_idx    <= '0;
        input_error <= 1'b0;
      end
      if (append) begin
        seq_mem[round_len[ADDR_W-1:0]] <= new_sym;
        round_len <= round_len + ONE_LEN;
        show_idx  <= '0;
      end
      if (show_adv) show_idx <= show_idx + ONE_LEN;
      if (enter_wait) input_index <= '0;
      if (press_ok) input_index <= input_index + ONE_LEN;
      if (press_bad || timeout_now) input_error <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: doc/simon_sequence_engine.md
SIMON_SEQUENCE_ENGINE -- requirements
Module: simon_sequence_engine

Interface
REQ-001 SHALL have parameter NUM_BTN, default 4, number of buttons/symbols (2..8).
REQ-002 SHALL have parameter MAX_LEN, default 16, maximum sequence length (2..64).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1000000, idle cycles allowed between presses.
REQ-004 SHALL have port clk  in  1  clock.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  in  1  begin new game; sampled in IDLE, FAIL or WIN only.
REQ-007 SHALL have port seed  in  16  LFSR seed, loaded on accepted start; value 0 is replaced by 16'hACE1.
REQ-008 SHALL have port buttons  in  NUM_BTN  synchronised, debounced button levels.
REQ-009 SHALL have port show_valid  out  1  playback symbol valid.
REQ-010 SHALL have port show_sym  out  SYM_W  playback symbol index.
REQ-011 SHALL have port show_ready  in  1  display accepted symbol.
REQ-012 SHALL have port round_len  out  LEN_W  current sequence length.
REQ-013 SHALL have port input_index  out  LEN_W  position of the next expected press.
REQ-014 SHALL have port round_pass  out  1  one-cycle pulse on round completion.
REQ-015 SHALL have port input_error  out  1  sticky error flag, cleared on start.
REQ-016 SHALL have port game_won  out  1  level, high in WIN.
REQ-017 SHALL have port busy  out  1  high in any state except IDLE, FAIL and WIN.

Function
REQ-018 SHALL implement states IDLE, EXTEND, SHOW, WAIT_IN, FAIL and WIN.
REQ-019 SHALL, on start, load the LFSR, clear the stored sequence, set round_len=0 and enter EXTEND.
REQ-020 SHALL, in EXTEND, append LFSR[SYM_W-1:0] mod NUM_BTN at index round_len, increment round_len, step the LFSR and enter SHOW, in one cycle.
REQ-021 SHALL, in SHOW, present symbols 0..round_len-1 with a valid/ready handshake; show_sym SHALL be held stable while show_valid=1 and show_ready=0.
REQ-022 SHALL enter WAIT_IN with input_index=0 in the cycle after the last symbol is accepted.
REQ-023 SHALL define a press event as buttons changing from all-zero to nonzero; no further press SHALL be recognised until buttons return to all-zero.
REQ-024 SHALL treat a press event with more than one bit set as a wrong symbol.
REQ-025 SHALL, on a correct press, increment input_index; on the final index it SHALL pulse round_pass and enter EXTEND, or enter WIN if round_len==MAX_LEN.
REQ-026 SHALL, on a wrong press, set input_error and enter FAIL.
REQ-027 SHALL ignore buttons outside WAIT_IN; buttons already held when WAIT_IN is entered SHALL NOT count as a press.
REQ-028 SHALL ignore start while busy=1.
REQ-029 SHALL compute widths as SYM_W=$clog2(NUM_BTN) and LEN_W=$clog2(MAX_LEN+1).

Reset
REQ-030 SHALL, on reset, enter IDLE and drive all outputs to 0 (show_sym, round_len and input_index included).
REQ-031 SHALL, if reset is asserted mid-game, abandon the game immediately; no pulse SHALL be emitted on reset release.

Configuration
REQ-032 SHALL, with SIMON_TIMEOUT_EN defined, count cycles in WAIT_IN since the last press or WAIT_IN entry, and on reaching TIMEOUT_CYC set input_error and enter FAIL.
REQ-033 SHALL, without SIMON_TIMEOUT_EN, contain no timeout counter, and WAIT_IN SHALL wait indefinitely.

Structure
REQ-034 SHALL place the state enum type and the LFSR reset-seed constant 16'hACE1 in the package simon_pkg.
REQ-035 SHALL implement the LFSR as sub-module simon_lfsr: 16-bit Fibonacci LFSR, taps 16,14,13,11, with load and step inputs.

Verification
REQ-036 SHALL cover a full game: NUM_BTN=4, MAX_LEN=3, show_ready=1, echoing each shown sequence -> three round_pass pulses, then game_won=1 and round_len=3.
REQ-037 SHALL cover a wrong symbol: a wrong button at index 1 of round 2 -> input_error=1, FAIL state, busy=0; a subsequent start clears input_error.
REQ-038 SHALL cover two simultaneous buttons: buttons=4'b0011 pressed -> input_error=1.
REQ-039 SHALL cover playback backpressure: show_ready low for 5 cycles -> show_sym and show_valid held stable throughout, with no symbol skipped.
REQ-040 SHALL cover held buttons: a button held across SHOW->WAIT_IN -> no press is counted until release and re-press.
REQ-041 SHALL cover the timeout: with SIMON_TIMEOUT_EN and TIMEOUT_CYC=10 and no press -> input_error=1 exactly 10 cycles after entering WAIT_IN.
